// File: rtl/strip_cmd_sequencer.sv
// Clocked command sequencer for the LED strip: valid/ready op_code decode, power/mode/color/
// brightness state with a one-deep color memory, a debounce lockout and a frame scheduler.
module strip_cmd_sequencer #(
   parameter int unsigned FRAME_DIV = 50,
   parameter int unsigned LOCKOUT   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [3:0] op_code,
   output logic       cmd_ready,
   output logic       power_on,
   output logic [1:0] mode,
   output logic [2:0] color_code,
   output logic [2:0] brightness,
   output logic       flash_phase,
   output logic       rainbow_step,
   output logic       frame_tick,
   output logic       cfg_changed
);

   typedef enum logic [1:0] {S_OFF, S_IDLE, S_LOCK} state_e;
   typedef enum logic [1:0] {M_SOLID = 2'd0, M_FLASH = 2'd1, M_RAINBOW = 2'd2} mode_e;

   localparam logic [3:0] OP_NOP        = 4'd0;
   localparam logic [3:0] OP_RELOAD     = 4'd1;
   localparam logic [3:0] OP_MODE_NEXT  = 4'd2;
   localparam logic [3:0] OP_MODE_PREV  = 4'd3;
   localparam logic [3:0] OP_COLOR_NEXT = 4'd4;
   localparam logic [3:0] OP_COLOR_BACK = 4'd5;
   localparam logic [3:0] OP_BRIGHT_UP  = 4'd6;
   localparam logic [3:0] OP_BRIGHT_DN  = 4'd7;

   localparam bit          USE_LOCK   = (LOCKOUT > 0);
   localparam logic [7:0]  LOCK_LOAD  = USE_LOCK ? 8'(LOCKOUT - 1) : 8'd0;
   localparam logic [15:0] FRAME_LAST = 16'(FRAME_DIV - 1);

   state_e      state_q;
   logic [7:0]  lock_cnt_q;
   logic        power_q, power_d;
   mode_e       mode_q, mode_d;
   logic [2:0]  color_q, color_d;
   logic [2:0]  saved_q, saved_d;
   logic [2:0]  bright_q, bright_d;
   logic        cfg_q;
   logic [15:0] frame_cnt_q;
   logic        flash_q, step_q, tick_q;

   logic accept, power_up, mode_chg, cfg_chg, frame_wrap;

   assign cmd_ready  = (state_q != S_LOCK);
   assign accept     = cmd_valid && cmd_ready;
   assign power_up   = accept && (state_q == S_OFF) && (op_code == OP_RELOAD);
   assign mode_chg   = (mode_d != mode_q);
   assign cfg_chg    = power_up || mode_chg || (color_d != color_q) || (bright_d != bright_q);
   assign frame_wrap = (frame_cnt_q == FRAME_LAST);

   always_comb begin
      // NOTE: every _d takes its hold value first, so no decode path can infer a latch.
      power_d  = power_q;
      mode_d   = mode_q;
      color_d  = color_q;
      saved_d  = saved_q;
      bright_d = bright_q;
      if (accept) begin
         if (state_q == S_OFF) begin
            if (op_code == OP_RELOAD) begin
               power_d  = 1'b1;
               mode_d   = M_SOLID;
               color_d  = 3'd0;
               saved_d  = 3'd0;
               bright_d = 3'd7;
            end
         end else begin
            case (op_code)
               OP_RELOAD: begin
                  mode_d   = M_SOLID;
                  color_d  = 3'd0;
                  saved_d  = 3'd0;
                  bright_d = 3'd7;
               end
               OP_MODE_NEXT: begin
                  case (mode_q)
                     M_SOLID: mode_d = M_FLASH;
                     M_FLASH: mode_d = M_RAINBOW;
                     default: mode_d = M_SOLID;
                  endcase
               end
               OP_MODE_PREV: begin
                  case (mode_q)
                     M_SOLID:   mode_d = M_RAINBOW;
                     M_RAINBOW: mode_d = M_FLASH;
                     default:   mode_d = M_SOLID;
                  endcase
               end
               OP_COLOR_NEXT: begin
                  saved_d = color_q;
                  color_d = color_q + 3'd1;
               end
               OP_COLOR_BACK: color_d = saved_q;
               OP_BRIGHT_UP:  if (bright_q != 3'd7) bright_d = bright_q + 3'd1;
               OP_BRIGHT_DN:  if (bright_q != 3'd0) bright_d = bright_q - 3'd1;
               default: begin
                  // Direct color select; selecting the current color leaves the memory alone
                  if (op_code[3] && (op_code[2:0] != color_q)) begin
                     saved_d = color_q;
                     color_d = op_code[2:0];
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_OFF;
         lock_cnt_q <= 8'd0;
         power_q    <= 1'b0;
         mode_q     <= M_SOLID;
         color_q    <= 3'd0;
         saved_q    <= 3'd0;
         bright_q   <= 3'd7;
         cfg_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking updates, so every register sees the same pre-edge values.
         power_q  <= power_d;
         mode_q   <= mode_d;
         color_q  <= color_d;
         saved_q  <= saved_d;
         bright_q <= bright_d;
         cfg_q    <= cfg_chg;
         case (state_q)
            S_OFF: begin
               if (power_up) begin
                  state_q    <= USE_LOCK ? S_LOCK : S_IDLE;
                  lock_cnt_q <= LOCK_LOAD;
               end
            end
            S_IDLE: begin
               if (accept && (op_code != OP_NOP)) begin
                  state_q    <= USE_LOCK ? S_LOCK : S_IDLE;
                  lock_cnt_q <= LOCK_LOAD;
               end
            end
            S_LOCK: begin
               if (lock_cnt_q == 8'd0) state_q <= S_IDLE;
               else                    lock_cnt_q <= lock_cnt_q - 8'd1;
            end
            default: state_q <= S_OFF;
         endcase
      end
   end

   // A mode change (or power-up) restarts the frame, suppressing any coincident wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
         flash_q     <= 1'b0;
         step_q      <= 1'b0;
         tick_q      <= 1'b0;
      end else if (!power_d) begin
         frame_cnt_q <= 16'd0;
         flash_q     <= 1'b0;
         step_q      <= 1'b0;
         tick_q      <= 1'b0;
      end else if (power_up || mode_chg) begin
         frame_cnt_q <= 16'd0;
         flash_q     <= 1'b1;
         step_q      <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         frame_cnt_q <= frame_wrap ? 16'd0 : frame_cnt_q + 16'd1;
         tick_q      <= frame_wrap;
         step_q      <= frame_wrap && (mode_q == M_RAINBOW);
         if (mode_q != M_FLASH) flash_q <= 1'b1;
         else if (frame_wrap)   flash_q <= ~flash_q;
      end
   end

   assign power_on     = power_q;
   assign mode         = mode_q;
   assign color_code   = color_q;
   assign brightness   = bright_q;
   assign cfg_changed  = cfg_q;
   assign flash_phase  = flash_q;
   assign rainbow_step = step_q;
   assign frame_tick   = tick_q;

endmodule

// File: doc/strip_cmd_sequencer.md
Name: strip_cmd_sequencer

Overview:
- Registered command sequencer for the LED strip datapath. It replaces the free-running combinational op_code muxes with one clocked state holder.
- It accepts 4-bit op_codes through a valid/ready handshake and holds power, mode, color and brightness state, including a one-deep previous-color memory.
- It applies a post-command lockout for button debounce.
- It runs a frame scheduler that produces the flash phase and the rainbow shift strobes consumed by the strip datapath.

Parameters:
- FRAME_DIV, 50: clk cycles per frame; legal range is 2 to 65535.
- LOCKOUT, 4: cycles during which cmd_ready stays low after a state-changing command; 0 disables the lockout; maximum is 255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  op_code is valid this cycle.
- op_code  in  4  command; encoding as given under Behaviour.
- cmd_ready  out  1  block will accept a command this cycle.
- power_on  out  1  system is on.
- mode  out  2  0 solid, 1 flashing, 2 rainbow; the value 3 never occurs.
- color_code  out  3  current color index.
- brightness  out  3  0 to 7.
- flash_phase  out  1  gate for solid color in flashing mode.
- rainbow_step  out  1  one-cycle pulse that rotates the rainbow pattern by one LED.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- cfg_changed  out  1  one-cycle pulse after any change to mode, color or brightness.

Behaviour:
- Reset (asynchronous): state OFF; power_on=0; mode=0; color_code=0; saved_color=0; brightness=7; lock_cnt=0; frame_cnt=0; flash_phase=0; rainbow_step=0; frame_tick=0; cfg_changed=0. Deasserting rst mid-lockout or mid-frame restarts cleanly from OFF.
- Handshake: a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1. The register update takes effect at that same edge, so new values are visible in the following cycle. cfg_changed is high for the one cycle after that edge, and only if some value actually changed.
- cmd_ready is 1 in OFF and in IDLE, and 0 in LOCK.
- FSM states: OFF, IDLE, LOCK.
  - OFF: any accepted op other than 1 is dropped. Op 1 sets power_on=1, mode=0, color_code=0, saved_color=0, brightness=7, pulses cfg_changed, and moves to LOCK, or to IDLE when LOCKOUT=0.
  - IDLE: op 0 is accepted with no effect and no lockout. Any other op is applied and moves to LOCK (or stays IDLE when LOCKOUT=0), even if the op made no change.
  - LOCK: lock_cnt loads LOCKOUT-1 on entry and decrements each cycle. Return to IDLE on the cycle after lock_cnt reaches 0, so cmd_ready is low for exactly LOCKOUT cycles.
- Op encoding while on:
  - 1: reload defaults; same values as the power-on load from OFF.
  - 2: mode next, 0→1→2→0.
  - 3: mode previous, 0→2→1→0.
  - 4: saved_color=color_code; color_code=color_code+1, wrapping 7→0.
  - 5: color_code=saved_color; saved_color is unchanged, so a repeated 5 is idempotent.
  - 6: brightness+1, saturating at 7.
  - 7: brightness−1, saturating at 0.
  - 8 to 15: if op_code[2:0] differs from color_code, then saved_color=color_code and color_code=op_code[2:0]; otherwise no change and no cfg_changed.
- Frame scheduler:
  - Runs only while power_on=1; while off, frame_cnt holds 0 and all strobes are 0.
  - frame_cnt counts 0 to FRAME_DIV-1 and wraps. frame_tick=1 for the one cycle after the counter wraps.
  - Flashing (mode 1): flash_phase toggles on each frame_tick. In other modes flash_phase is held at 1.
  - Rainbow (mode 2): rainbow_step = frame_tick; in other modes rainbow_step is 0.
  - Any accepted mode change clears frame_cnt to 0 and sets flash_phase=1 at the same edge.
  - If a wrap coincides with a mode-change accept, the mode change wins: no frame_tick is issued for that wrap.
- cfg_changed and frame_tick may be high in the same cycle.

Test Plan:
1. After reset, op 6 with valid → dropped, cmd_ready stays 1, brightness stays 7. Then op 1 → power_on=1, mode=0, color=0, brightness=7, cfg_changed pulses once, cmd_ready low for exactly 4 cycles.
2. Three op 2 commands, each sent after ready returns → mode goes 1, 2, 0. Then op 3 → mode=2. While in mode 2 with FRAME_DIV=4, rainbow_step pulses every 4 cycles. In mode 1, flash_phase toggles every 4 cycles, starting from 1 after the mode change.
3. Color sequence: op 4 ×4 → color 4, saved 3. Op 5 → color 3. Op 5 again → color 3 with no cfg_changed. Op 4 at color 7 → color wraps to 0.
4. Op 15 → color 7, saved 0. Op 15 again → no change, no cfg_changed, lockout still applied. Op 13 → color 5, saved 7.
5. Brightness: op 6 ×2 from 7 → stays 7, no pulse. Op 7 ×8 → reaches 0 and stays 0 on the final command.
6. Holding cmd_valid=1 through the lockout → only 1 accept per 5 cycles. Asserting rst during LOCK → immediately OFF with all reset values, while the frame counter is mid-count.
